// File: rtl/superfx_defs.sv
// rtl/superfx_defs.sv - shared sequencer state encodings, opcode constants, branch condition selects
package superfx_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OPER  = 2'd2,
    ST_DELAY = 2'd3
  } seq_state_t;

  localparam logic [7:0] OP_STOP   = 8'h00;
  localparam logic [7:0] OP_BRA_LO = 8'h05;
  localparam logic [7:0] OP_BRA_HI = 8'h0F;
  localparam logic [7:0] OP_LOOP   = 8'h3C;

  // Condition select is the low nibble of the branch opcode.
  localparam logic [3:0] CC_BRA = 4'h5;
  localparam logic [3:0] CC_BGE = 4'h6;
  localparam logic [3:0] CC_BLT = 4'h7;
  localparam logic [3:0] CC_BNE = 4'h8;
  localparam logic [3:0] CC_BEQ = 4'h9;
  localparam logic [3:0] CC_BPL = 4'hA;
  localparam logic [3:0] CC_BMI = 4'hB;
  localparam logic [3:0] CC_BCC = 4'hC;
  localparam logic [3:0] CC_BCS = 4'hD;
  localparam logic [3:0] CC_BVC = 4'hE;
  localparam logic [3:0] CC_BVS = 4'hF;

  function automatic logic is_branch_op(input logic [7:0] op);
    return (op >= OP_BRA_LO) && (op <= OP_BRA_HI);
  endfunction

endpackage

// File: rtl/fig_17_branch_cond.sv
// rtl/fig_17_branch_cond.sv - combinational branch condition evaluation from latched select and flags
module fig_17_branch_cond
  import superfx_defs::*;
(
  input  logic [3:0] cond_sel,
  input  logic       flag_z,
  input  logic       flag_cy,
  input  logic       flag_s,
  input  logic       flag_ov,
  output logic       taken
);

  // Decode the condition select against the current flags
  always_comb begin
    taken = 1'b0;
    case (cond_sel)
      CC_BRA:  taken = 1'b1;
      CC_BGE:  taken = ~(flag_s ^ flag_ov);
      CC_BLT:  taken = flag_s ^ flag_ov;
      CC_BNE:  taken = ~flag_z;
      CC_BEQ:  taken = flag_z;
      CC_BPL:  taken = ~flag_s;
      CC_BMI:  taken = flag_s;
      CC_BCC:  taken = ~flag_cy;
      CC_BCS:  taken = flag_cy;
      CC_BVC:  taken = ~flag_ov;
      CC_BVS:  taken = flag_ov;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fig_17_pc_sequencer.sv
// rtl/fig_17_pc_sequencer.sv - R15 fetch/flow sequencer; FIG17_PERF_CNT_EN adds the perf_cnt output
module fig_17_pc_sequencer
  import superfx_defs::*;
#(
  parameter int PC_W  = 16,
  parameter int OFF_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go_set,
  input  logic            go_clr,
  input  logic            hold,
  output logic            fetch_req,
  input  logic            fetch_ack,
  input  logic [7:0]      fetch_data,
  input  logic [PC_W-1:0] pc,
  input  logic            flag_z,
  input  logic            flag_cy,
  input  logic            flag_s,
  input  logic            flag_ov,
  input  logic            r12_is_one,
  output logic            loop_dec,
  output logic            op_valid,
  output logic [7:0]      op_code,
  output logic            pc_en,
  output logic            pc_loop,
  output logic            pc_load,
  output logic            pc_hold,
  output logic [PC_W-1:0] pc_target,
  output logic            go,
  output logic            stop_irq
`ifdef FIG17_PERF_CNT_EN
  ,
  output logic [15:0]     perf_cnt
`endif
);

  seq_state_t      state, state_n;
  logic            go_q, go_n;
  logic [3:0]      cond_q, cond_n;
  logic            br_pend, br_pend_n;
  logic            loop_pend, loop_pend_n;
  logic [PC_W-1:0] target_q, target_n;
  logic [PC_W-1:0] branch_dest;
  logic [OFF_W-1:0] offset;
  logic            taken;

  // Offset is relative to the address following the operand byte
  assign offset      = fetch_data[OFF_W-1:0];
  assign branch_dest = pc + PC_W'(1) + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};

  fig_17_branch_cond u_cond (
    .cond_sel (cond_q),
    .flag_z   (flag_z),
    .flag_cy  (flag_cy),
    .flag_s   (flag_s),
    .flag_ov  (flag_ov),
    .taken    (taken)
  );

  assign fetch_req = (state != ST_IDLE) && !hold;
  assign pc_hold   = hold;
  assign pc_target = target_q;
  assign go        = go_q;

  // Sequencer state, GO, latched condition, pend flags and branch target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      go_q      <= 1'b0;
      cond_q    <= 4'h0;
      br_pend   <= 1'b0;
      loop_pend <= 1'b0;
      target_q  <= '0;
    end else begin
      state     <= state_n;
      go_q      <= go_n;
      cond_q    <= cond_n;
      br_pend   <= br_pend_n;
      loop_pend <= loop_pend_n;
      target_q  <= target_n;
    end
  end

  // Next-state and strobe decode; go_clr overrides everything, hold freezes everything else
  always_comb begin
    state_n     = state;
    go_n        = go_q;
    cond_n      = cond_q;
    br_pend_n   = br_pend;
    loop_pend_n = loop_pend;
    target_n    = target_q;
    loop_dec    = 1'b0;
    op_valid    = 1'b0;
    op_code     = 8'h00;
    pc_en       = 1'b0;
    pc_loop     = 1'b0;
    pc_load     = 1'b0;
    stop_irq    = 1'b0;
    if (go_clr) begin
      state_n     = ST_IDLE;
      go_n        = 1'b0;
      br_pend_n   = 1'b0;
      loop_pend_n = 1'b0;
    end else if (!hold) begin
      case (state)
        ST_IDLE: begin
          if (go_set) begin
            go_n    = 1'b1;
            state_n = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (fetch_ack) begin
            pc_en = 1'b1;
            if (fetch_data == OP_STOP) begin
              go_n     = 1'b0;
              stop_irq = 1'b1;
              state_n  = ST_IDLE;
            end else if (is_branch_op(fetch_data)) begin
              cond_n  = fetch_data[3:0];
              state_n = ST_OPER;
            end else if (fetch_data == OP_LOOP) begin
              loop_dec = 1'b1;
              if (!r12_is_one) begin
                loop_pend_n = 1'b1;
                state_n     = ST_DELAY;
              end
            end else begin
              op_valid = 1'b1;
              op_code  = fetch_data;
            end
          end
        end
        ST_OPER: begin
          if (fetch_ack) begin
            pc_en    = 1'b1;
            target_n = branch_dest;
            if (taken) begin
              br_pend_n = 1'b1;
              state_n   = ST_DELAY;
            end else begin
              state_n = ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          if (fetch_ack) begin
            // Delay-slot byte always executes as a plain opcode, even if it encodes flow
            op_valid = 1'b1;
            op_code  = fetch_data;
            if (br_pend) begin
              pc_load = 1'b1;
            end else if (loop_pend) begin
              pc_loop = 1'b1;
            end else begin
              pc_en = 1'b1;
            end
            br_pend_n   = 1'b0;
            loop_pend_n = 1'b0;
            state_n     = ST_FETCH;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

`ifdef FIG17_PERF_CNT_EN
  logic flow_ev;

  assign flow_ev = stop_irq | loop_dec |
                   ((state == ST_FETCH) && pc_en && is_branch_op(fetch_data));

  // Saturating count of executed opcodes, restarted by each go_set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cnt <= 16'h0000;
    end else if (go_set) begin
      perf_cnt <= 16'h0000;
    end else if ((op_valid || flow_ev) && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'h0001;
    end
  end
`endif

endmodule
